// File: rtl/log_pkg.sv
//------------------------------------------------------------------------------
// Module      : log_pkg
// Description : Shared types for the event log buffer (levels, entry record).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package log_pkg;

    localparam int LOG_DATA_W = 32;
    localparam int LOG_TS_W   = 32;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        LVL_DEBUG = 2'd0,
        LVL_INFO  = 2'd1,
        LVL_WARN  = 2'd2,
        LVL_RSVD  = 2'd3
    } level_e;

    typedef struct packed {
        level_e                level;
        logic [LOG_DATA_W-1:0] data;
        logic [LOG_TS_W-1:0]   ts;
    } log_entry_t;

    // Reserved level never passes, regardless of threshold.
    function automatic logic level_passes(input logic [1:0] lvl, input logic [1:0] min_lvl);
        return (lvl != LVL_RSVD) && (lvl >= min_lvl);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module      : sync_fifo
// Description : First-word fall-through FIFO of log entries; head reads as 0 when empty.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo
    import log_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  log_entry_t                 i_wr_entry,
    output log_entry_t                 o_rd_entry,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_fill
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = $clog2(DEPTH+1);

    log_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_FILL_W-1:0]   r_fill;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_fill == '0);
    assign o_full  = (r_fill == c_FILL_W'(DEPTH));
    assign o_fill  = r_fill;

    assign w_pop  = i_pop & ~o_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push = i_push & (~o_full | w_pop);

    assign o_rd_entry = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_entry;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_W'(1);
                2'b01:   r_fill <= r_fill - c_FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_log_buffer.sv
//------------------------------------------------------------------------------
// Module      : event_log_buffer
// Description : Filters and timestamps severity-tagged events into a FWFT FIFO.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module event_log_buffer
    import log_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TS_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_enable,
    input  logic [1:0]                 cfg_min_level,
    input  logic                       ev_valid,
    input  logic [1:0]                 ev_level,
    input  logic [DATA_W-1:0]          ev_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_level,
    output logic [DATA_W-1:0]          out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    logic [TS_W-1:0]       r_ts;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_empty;
    log_entry_t            w_wr_entry;
    log_entry_t            w_rd_entry;

    assign w_accept = ev_valid & cfg_enable & level_passes(ev_level, cfg_min_level);
    assign w_pop    = out_valid & out_ready;
    assign w_push   = w_accept & (~full | w_pop);
    assign w_drop   = w_accept & full & ~w_pop;

    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.level = level_e'(ev_level);
        w_wr_entry.data  = LOG_DATA_W'(ev_data);
        w_wr_entry.ts    = LOG_TS_W'(r_ts);
    end

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wr_entry (w_wr_entry),
        .o_rd_entry (w_rd_entry),
        .o_empty    (w_empty),
        .o_full     (full),
        .o_fill     (fill)
    );

    assign out_valid = ~w_empty;
    assign out_level = w_rd_entry.level;
    assign out_data  = w_rd_entry.data[DATA_W-1:0];
    assign out_ts    = w_rd_entry.ts[TS_W-1:0];
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            // Saturate so a long overflow episode never reads back as a small count.
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_event_log_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_event_log_buffer
// Description : Directed self-checking bench for event_log_buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_event_log_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [1:0]  cfg_min_level;
    logic        ev_valid;
    logic [1:0]  ev_level;
    logic [31:0] ev_data;
    logic        out_ready;

    logic        out_valid;
    logic [1:0]  out_level;
    logic [31:0] out_data;
    logic [31:0] out_ts;
    logic [4:0]  fill;
    logic        full;
    logic [15:0] drop_cnt;

    logic        out_valid4;
    logic [1:0]  out_level4;
    logic [31:0] out_data4;
    logic [3:0]  out_ts4;
    logic [4:0]  fill4;
    logic        full4;
    logic [15:0] drop_cnt4;

    int checks = 0;
    int errors = 0;
    logic [31:0] ts0;

    always #5 clk = ~clk;

    event_log_buffer #(.DEPTH(16), .DATA_W(32), .TS_W(32)) u_dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_min_level(cfg_min_level),
        .ev_valid(ev_valid), .ev_level(ev_level), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
        .out_data(out_data), .out_ts(out_ts), .fill(fill), .full(full), .drop_cnt(drop_cnt)
    );

    event_log_buffer #(.DEPTH(16), .DATA_W(32), .TS_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_min_level(cfg_min_level),
        .ev_valid(ev_valid), .ev_level(ev_level), .ev_data(ev_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_level(out_level4),
        .out_data(out_data4), .out_ts(out_ts4), .fill(fill4), .full(full4), .drop_cnt(drop_cnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_enable = 1'b1; cfg_min_level = 2'd0;
        ev_valid = 1'b0; ev_level = 2'd0; ev_data = '0; out_ready = 1'b0;

        // Reset and timestamp origin
        repeat (3) step();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ts", 64'(out_ts), 64'd0);
        repeat (5) step();
        ev_valid = 1'b1; ev_level = 2'd2; ev_data = 32'hDEAD;
        step();
        ev_valid = 1'b0;
        check("ts5_valid", 64'(out_valid), 64'd1);
        check("ts5_ts", 64'(out_ts), 64'd5);
        check("ts5_data", 64'(out_data), 64'hDEAD);
        out_ready = 1'b1;
        step();
        check("ts5_drained", 64'(fill), 64'd0);
        step();
        check("ready_empty_fill", 64'(fill), 64'd0);
        check("ready_empty_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Level filter
        cfg_min_level = 2'd1;
        ev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev_level = 2'(i); ev_data = 32'd100 + 32'(i);
            step();
        end
        ev_valid = 1'b0;
        check("filt_fill", 64'(fill), 64'd2);
        check("filt_head_data", 64'(out_data), 64'd101);
        check("filt_head_level", 64'(out_level), 64'd1);
        out_ready = 1'b1;
        step();
        check("filt_2nd_data", 64'(out_data), 64'd102);
        check("filt_2nd_level", 64'(out_level), 64'd2);
        step();
        check("filt_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        cfg_min_level = 2'd0;

        // Ordering and consecutive timestamps
        ev_valid = 1'b1; ev_level = 2'd1;
        for (int i = 0; i < 16; i++) begin
            ev_data = 32'(i);
            step();
        end
        ev_valid = 1'b0;
        check("ord_full", 64'(full), 64'd1);
        check("ord_fill", 64'(fill), 64'd16);
        ts0 = out_ts;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ord_data", 64'(out_data), 64'(i));
            check("ord_ts", 64'(out_ts), 64'(ts0 + 32'(i)));
            step();
        end
        check("ord_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Overflow
        ev_valid = 1'b1; ev_level = 2'd2;
        for (int i = 0; i < 20; i++) begin
            ev_data = 32'd200 + 32'(i);
            step();
        end
        ev_valid = 1'b0;
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_fill", 64'(fill), 64'd16);
        check("ovf_drop", 64'(drop_cnt), 64'd4);
        check("ovf_head", 64'(out_data), 64'd200);

        // Push and pop together while full
        ev_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ev_data = 32'd300 + 32'(i);
            step();
            check("pp_fill", 64'(fill), 64'd16);
        end
        ev_valid = 1'b0; out_ready = 1'b0;
        check("pp_drop", 64'(drop_cnt), 64'd4);
        check("pp_head", 64'(out_data), 64'd208);

        // Disabled events are not drops; enabled ones are
        cfg_enable = 1'b0; ev_valid = 1'b1;
        step();
        check("dis_drop", 64'(drop_cnt), 64'd4);
        cfg_enable = 1'b1;
        step();
        ev_valid = 1'b0;
        check("en_drop", 64'(drop_cnt), 64'd5);
        check("en_head", 64'(out_data), 64'd208);

        // Reset mid-operation
        rst = 1'b1;
        step();
        check("mid_rst_fill", 64'(fill), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;

        // Timestamp wrap on the 4-bit instance
        repeat (15) step();
        ev_valid = 1'b1; ev_level = 2'd2; ev_data = 32'hA;
        step();
        ev_data = 32'hB;
        step();
        ev_valid = 1'b0;
        check("wrap_ts_first", 64'(out_ts4), 64'd15);
        check("wide_ts_first", 64'(out_ts), 64'd15);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("wrap_ts_second", 64'(out_ts4), 64'd0);
        check("wide_ts_second", 64'(out_ts), 64'd16);
        check("wrap_data_second", 64'(out_data4), 64'hB);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        ev_valid = 1'b1;
        repeat (5) step();
        ev_valid = 1'b0;
        check("wrap_fill5", 64'(fill4), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wrap_rst_fill", 64'(fill4), 64'd0);
        check("wrap_rst_valid", 64'(out_valid4), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
